// File: rtl/jamma_joy_scanner.sv
// Time-multiplexed JAMMA input scanner: drives the shared select line, samples
// each player's button bus in turn and debounces buttons and coins per bit.
`timescale 1ns/1ps

module jamma_joy_scanner #(
  parameter int SETTLE_CYCLES    = 4,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic [7:0] I_JJOY,
  input  logic [1:0] I_COIN,
  input  logic [5:0] I_KEYJOY,
  output logic       O_SELECT,
  output logic [7:0] O_JOY_A,
  output logic [7:0] O_JOY_B,
  output logic [1:0] O_COIN,
  output logic       O_SCAN_TICK
);

  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("jamma_joy_scanner: SETTLE_CYCLES must be in 2..255");
  end
  if (DEBOUNCE_SAMPLES < 1 || DEBOUNCE_SAMPLES > 15) begin : g_bad_debounce
    $error("jamma_joy_scanner: DEBOUNCE_SAMPLES must be in 1..15");
  end

  typedef enum logic [1:0] {A_SETTLE, A_SAMPLE, B_SETTLE, B_SAMPLE} scan_state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [4:0] DB_TARGET   = 5'(DEBOUNCE_SAMPLES);
  localparam int         NBITS       = 18;

  logic [7:0]  jj_meta, jj_s;
  logic [1:0]  coin_meta, coin_s;
  scan_state_t state, next_state;
  logic [7:0]  cnt, cnt_next;
  logic        select_next, tick_next;
  logic        sample_a, sample_b;
  logic [NBITS-1:0] samp, en, q;
  logic [3:0]  dc [NBITS];

  // Idle (released) level is all ones, so reset the synchronizers to 1s.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      jj_meta   <= '1;
      jj_s      <= '1;
      coin_meta <= '1;
      coin_s    <= '1;
    end else begin
      jj_meta   <= I_JJOY;
      jj_s      <= jj_meta;
      coin_meta <= I_COIN;
      coin_s    <= coin_meta;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state       <= A_SETTLE;
      cnt         <= '0;
      O_SELECT    <= 1'b0;
      O_SCAN_TICK <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_next;
      O_SELECT    <= select_next;
      O_SCAN_TICK <= tick_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      A_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          next_state = A_SAMPLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      A_SAMPLE: begin
        next_state = B_SETTLE;
        cnt_next   = '0;
      end
      B_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          next_state = B_SAMPLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      B_SAMPLE: begin
        next_state = A_SETTLE;
        cnt_next   = '0;
      end
      default: begin
        next_state = A_SETTLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the flops match the state.
  always_comb begin
    select_next = (next_state == B_SETTLE) || (next_state == B_SAMPLE);
    tick_next   = (next_state == B_SAMPLE);
  end

  assign sample_a = (state == A_SAMPLE);
  assign sample_b = (state == B_SAMPLE);
  assign samp     = {coin_s, jj_s, jj_s};
  assign en       = {{2{sample_a}}, {8{sample_b}}, {8{sample_a}}};

  // Bits [7:0] player A, [15:8] player B, [17:16] coins; each counts alone.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      q <= '1;
      for (int i = 0; i < NBITS; i++) dc[i] <= '0;
    end else begin
      for (int i = 0; i < NBITS; i++) begin
        if (en[i]) begin
          if (samp[i] == q[i]) begin
            dc[i] <= '0;
          end else if (({1'b0, dc[i]} + 5'd1) == DB_TARGET) begin
            q[i]  <= samp[i];
            dc[i] <= '0;
          end else begin
            dc[i] <= dc[i] + 4'd1;
          end
        end
      end
    end
  end

  assign O_JOY_A = q[7:0] & {2'b11, I_KEYJOY};
  assign O_JOY_B = q[15:8];
  assign O_COIN  = q[17:16];

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// Directed bench for jamma_joy_scanner: default instance plus a fast
// SETTLE_CYCLES=2 / DEBOUNCE_SAMPLES=1 instance sharing clock and reset.
`timescale 1ns/1ps

module tb_jamma_joy_scanner;

  logic       clk;
  logic       rst;
  logic [7:0] pad_a, pad_b, pad2_a, pad2_b;
  logic [1:0] coin;
  logic [5:0] keyjoy;
  logic       sel, tick, sel2, tick2;
  logic [7:0] joy_a, joy_b, joy2_a, joy2_b;
  logic [1:0] coin_out, coin2_out;
  logic [7:0] jjoy, jjoy2;
  int         edge_num;
  int         tick_cnt;
  int         checks;
  int         errors;

  // The JAMMA harness presents whichever player the select line addresses.
  assign jjoy  = sel  ? pad_b  : pad_a;
  assign jjoy2 = sel2 ? pad2_b : pad2_a;

  jamma_joy_scanner dut (
    .I_CLK(clk), .I_RESET(rst), .I_JJOY(jjoy), .I_COIN(coin), .I_KEYJOY(keyjoy),
    .O_SELECT(sel), .O_JOY_A(joy_a), .O_JOY_B(joy_b), .O_COIN(coin_out),
    .O_SCAN_TICK(tick)
  );

  jamma_joy_scanner #(.SETTLE_CYCLES(2), .DEBOUNCE_SAMPLES(1)) dut_fast (
    .I_CLK(clk), .I_RESET(rst), .I_JJOY(jjoy2), .I_COIN(2'b11), .I_KEYJOY(6'h3F),
    .O_SELECT(sel2), .O_JOY_A(joy2_a), .O_JOY_B(joy2_b), .O_COIN(coin2_out),
    .O_SCAN_TICK(tick2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_num <= 0;
    else     edge_num <= edge_num + 1;
  end

  always @(negedge clk) if (tick === 1'b1) tick_cnt = tick_cnt + 1;

  task automatic waitToEdge(input int n);
    while (edge_num < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    tick_cnt = 0;
    rst      = 1'b1;
    pad_a    = 8'hFF;
    pad_b    = 8'hFF;
    pad2_a   = 8'hFF;
    pad2_b   = 8'hFF;
    coin     = 2'b11;
    keyjoy   = 6'h3F;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    pad_a = 8'hFE;
    pad_b = 8'h7F;

    waitToEdge(4);
    checkOutput("sel_e4", {7'd0, sel}, 8'h00);
    checkOutput("tick_e4", {7'd0, tick}, 8'h00);
    waitToEdge(5);
    checkOutput("sel_e5", {7'd0, sel}, 8'h01);
    waitToEdge(9);
    checkOutput("tick_e9", {7'd0, tick}, 8'h01);
    waitToEdge(10);
    checkOutput("sel_e10", {7'd0, sel}, 8'h00);
    checkOutput("tick_e10", {7'd0, tick}, 8'h00);
    tick_cnt = 0;
    pad2_a = 8'hFE;
    pad2_b = 8'h7F;
    waitToEdge(11);
    checkOutput("fast_tick_e11", {7'd0, tick2}, 8'h01);
    waitToEdge(14);
    checkOutput("fast_joy_a_e14", joy2_a, 8'hFF);
    waitToEdge(15);
    checkOutput("fast_joy_a_e15", joy2_a, 8'hFE);
    waitToEdge(17);
    checkOutput("fast_joy_b_e17", joy2_b, 8'hFF);
    waitToEdge(18);
    checkOutput("fast_joy_b_e18", joy2_b, 8'h7F);

    waitToEdge(34);
    checkOutput("sep_joy_a_e34", joy_a, 8'hFF);
    waitToEdge(35);
    checkOutput("sep_joy_a_e35", joy_a, 8'hFE);
    checkOutput("sep_joy_b_e35", joy_b, 8'hFF);
    waitToEdge(39);
    checkOutput("sep_joy_b_e39", joy_b, 8'hFF);
    waitToEdge(40);
    checkOutput("sep_joy_b_e40", joy_b, 8'h7F);
    checkOutput("sep_joy_a_e40", joy_a, 8'hFE);
    checkOutput("tick_count", 8'(tick_cnt), 8'd3);
    pad_a = 8'hFF;
    pad_b = 8'hFF;

    waitToEdge(75);
    checkOutput("release_joy_a", joy_a, 8'hFF);
    waitToEdge(80);
    checkOutput("release_joy_b", joy_b, 8'hFF);
    pad_a = 8'hF7;
    waitToEdge(105);
    checkOutput("glitch3_e105", joy_a, 8'hFF);
    pad_a = 8'hFF;
    waitToEdge(115);
    checkOutput("glitch3_e115", joy_a, 8'hFF);
    pad_a = 8'hF7;
    waitToEdge(154);
    checkOutput("glitch4_e154", joy_a, 8'hFF);
    waitToEdge(155);
    checkOutput("glitch4_e155", joy_a, 8'hF7);
    checkOutput("glitch4_joy_b", joy_b, 8'hFF);
    pad_a = 8'hFF;
    waitToEdge(195);
    checkOutput("glitch_release", joy_a, 8'hFF);

    waitToEdge(200);
    coin = 2'b10;
    waitToEdge(234);
    checkOutput("coin_e234", {6'd0, coin_out}, 8'h03);
    waitToEdge(235);
    checkOutput("coin_e235", {6'd0, coin_out}, 8'h02);
    waitToEdge(250);
    coin = 2'b11;
    waitToEdge(284);
    checkOutput("coin_e284", {6'd0, coin_out}, 8'h02);
    waitToEdge(285);
    checkOutput("coin_e285", {6'd0, coin_out}, 8'h03);

    waitToEdge(290);
    keyjoy = 6'b111011;
    #1;
    checkOutput("key_joy_a", joy_a, 8'hFB);
    checkOutput("key_joy_b", joy_b, 8'hFF);
    keyjoy = 6'h3F;
    #1;
    checkOutput("key_restore", joy_a, 8'hFF);

    waitToEdge(292);
    pad_a = 8'h00;
    pad_b = 8'h00;
    waitToEdge(325);
    checkOutput("held_joy_a", joy_a, 8'h00);
    waitToEdge(332);
    checkOutput("held_joy_b", joy_b, 8'h00);
    waitToEdge(337);
    checkOutput("pre_reset_sel", {7'd0, sel}, 8'h01);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_joy_a", joy_a, 8'hFF);
    checkOutput("rst_joy_b", joy_b, 8'hFF);
    checkOutput("rst_coin", {6'd0, coin_out}, 8'h03);
    checkOutput("rst_sel", {7'd0, sel}, 8'h00);
    checkOutput("rst_tick", {7'd0, tick}, 8'h00);
    pad_a = 8'hFF;
    pad_b = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    waitToEdge(4);
    checkOutput("rerun_sel_e4", {7'd0, sel}, 8'h00);
    waitToEdge(5);
    checkOutput("rerun_sel_e5", {7'd0, sel}, 8'h01);
    checkOutput("rerun_joy_a", joy_a, 8'hFF);
    waitToEdge(10);
    checkOutput("rerun_sel_e10", {7'd0, sel}, 8'h00);
    checkOutput("rerun_joy_b", joy_b, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jamma_joy_scanner.md
# jamma_joy_scanner

Time-multiplexed JAMMA input scanner for the arcade tops. It drives the shared JAMMA select line and captures each player's 8 active-low button lines from the single `JJOY` bus. Captured values pass through a per-bit debouncer, and the coin inputs get the same treatment. It sits directly upstream of the `PACMAN` core and feeds its `I_JOYSTICK_A/B`, `I_PLAYER` and `I_COIN` inputs, replacing the free-running per-cycle `JSELECT` toggle.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 4: extra cycles held in each select phase before sampling. Legal range is 2..255; values below 2 are a synthesis error.
- `DEBOUNCE_SAMPLES`, default 4: number of consecutive differing samples required before a debounced bit changes. Legal range is 1..15.

Ports:
- `I_CLK` in 1: system clock (pclk domain).
- `I_RESET` in 1: asynchronous, active-high reset.
- `I_JJOY` in 8: raw JAMMA button bus, active-low, asynchronous to `I_CLK`.
- `I_COIN` in 2: raw coin switches, active-low, asynchronous.
- `I_KEYJOY` in 6: keyboard joystick for player A, active-low, already synchronous.
- `O_SELECT` out 1: JAMMA select. 0 selects player A, 1 selects player B.
- `O_JOY_A` out 8: player A debounced buttons, active-low, AND-merged with `I_KEYJOY`.
- `O_JOY_B` out 8: player B debounced buttons, active-low.
- `O_COIN` out 2: debounced coins, active-low.
- `O_SCAN_TICK` out 1: one-cycle pulse on the edge that completes a full A+B scan.

## Operation

- **Synchronizer.** `I_JJOY` and `I_COIN` each pass through a 2-flop synchronizer. Call the outputs `jj_s` and `coin_s`.
- **State machine.** Four states, with a phase counter `cnt` (8-bit):
  - `A_SETTLE`: `O_SELECT`=0. `cnt` counts 0..SETTLE_CYCLES-1, then the FSM moves to `A_SAMPLE`.
  - `A_SAMPLE`: `O_SELECT`=0, one cycle. `jj_s` is applied to debouncer A and `coin_s` to the coin debouncer. Next state is `B_SETTLE`.
  - `B_SETTLE`: `O_SELECT`=1. Same counting as `A_SETTLE`, then the FSM moves to `B_SAMPLE`.
  - `B_SAMPLE`: `O_SELECT`=1, one cycle. `jj_s` is applied to debouncer B and `O_SCAN_TICK`=1. Next state is `A_SETTLE`.
- **Outputs.** `O_SELECT` is a registered state decode. `O_SCAN_TICK` is registered and high only in `B_SAMPLE`.
- **Debouncer.** One per bit; 8 for A, 8 for B, 2 for coin. Each has an output flop `q` and a 4-bit counter `dc`. On each sample event:
  - sample == `q`: `dc`←0.
  - sample != `q` and `dc`+1 == DEBOUNCE_SAMPLES: `q`←sample, `dc`←0.
  - otherwise: `dc`←`dc`+1.
  - No sample event: hold.
- **Output mapping.**
  - `O_JOY_A` = `qA` & {2'b11, `I_KEYJOY`}. This is combinational from the flops and the input.
  - `O_JOY_B` = `qB`.
  - `O_COIN` = `qC`.
- **Reset (asynchronous).** State=`A_SETTLE`, `cnt`=0, synchronizers all 1s, all `q` all 1s (released), all `dc`=0, `O_SELECT`=0, `O_SCAN_TICK`=0.
- **Reset mid-scan.** Everything returns to the reset values immediately; partial debounce counts are discarded.
- **Simultaneous changes.** Bits debounce independently; a bounce on one bit does not affect another bit's count.

## Timing

- Phase length is SETTLE_CYCLES+1 cycles. Full scan period P = 2·(SETTLE_CYCLES+1), which is 10 cycles at defaults.
- After reset deassertion, the first `A_SAMPLE` edge is edge number SETTLE_CYCLES+1 (edge 5), and the first `B_SAMPLE` edge is edge number 2·(SETTLE_CYCLES+1) (edge 10, where `O_SCAN_TICK` is seen high).
- Select-to-sample settling is SETTLE_CYCLES cycles. The 2-flop synchronizer therefore always sees the switched bus before sampling, because SETTLE_CYCLES ≥ 2.
- **Debounce latency.** For a change held stable on the pins, the output changes on the edge of the DEBOUNCE_SAMPLES-th sample of that player after the change reaches `jj_s`. This is at most DEBOUNCE_SAMPLES·P + 2 + P cycles.
- **Glitch rejection.** A glitch spanning fewer than DEBOUNCE_SAMPLES consecutive samples never reaches the output.
- **Keyboard path.** `I_KEYJOY` reaches `O_JOY_A` with 0-cycle combinational latency.

## Test plan

- **Reset values.** Assert `I_RESET` mid-scan with `I_JJOY`=8'h00 held. Required response: `O_JOY_A`=`O_JOY_B`=8'hFF, `O_COIN`=2'b11, `O_SELECT`=0, `O_SCAN_TICK`=0 immediately. After release, `O_SELECT` rises on edge 5, falls on edge 10, and `O_SCAN_TICK` is high for exactly one cycle every 10.
- **Player separation.** Drive `I_JJOY`=8'hFE while `O_SELECT`=0 and 8'h7F while `O_SELECT`=1. Required response: `O_JOY_A` settles to 8'hFE and `O_JOY_B` to 8'h7F, each on its 4th sample edge, with no cross-talk.
- **Glitch rejection.** A bit 3 low for 3 consecutive A samples, then high. Required response: `O_JOY_A` stays 8'hFF. Repeat with 4 consecutive samples: bit 3 goes low on the 4th A sample edge.
- **Coin.** `I_COIN`=2'b10 held for 50 cycles. Required response: `O_COIN`=2'b10 on the 4th A sample after synchronization, returning to 2'b11 4 samples after release.
- **Keyboard merge.** `I_KEYJOY`=6'b111011 with pins idle. Required response: `O_JOY_A`=8'hFB in the same cycle, and `O_JOY_B` unaffected.
- **Parameters.** With SETTLE_CYCLES=2 and DEBOUNCE_SAMPLES=1: period is 6 cycles, and any single sample change propagates on that sample edge.
